// File: rtl/downsampler_ber_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ber_pkg
// Description : Shared definitions for the decimating BER checker: FSM state
//               encoding and default values for the configuration parameters.
// Revision    : 1.0 - initial release
// ============================================================================
package ber_pkg;

  // SEARCH sweeps the candidate latencies; LOCKED counts bits and errors.
  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } ber_state_e;

  localparam int OS_DEFAULT     = 4;
  localparam int NB_LAT_DEFAULT = 9;
  localparam int NB_CNT_DEFAULT = 64;

endpackage
`default_nettype wire

// File: rtl/downsampler_ber_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all ones instead of wrapping.
//   clk     - rising-edge clock
//   i_rst   - asynchronous active-high clear
//   i_inc   - increment request, applied on the next rising edge
//   o_count - current count
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;

endmodule
`default_nettype wire

// File: rtl/downsampler_ber.sv
`default_nettype none
// ============================================================================
// Module      : downsampler_ber
// Description : Decimates an oversampled FIR output to one hard decision per
//               symbol, finds the reference latency with the fewest errors
//               by sweeping every candidate over a fixed window, then counts
//               compared bits and bit errors at that latency.
//   clk         - rising-edge clock
//   i_rst       - asynchronous active-high reset
//   i_en        - sample enable, 0 freezes all state
//   i_phase     - oversampled phase that produces the symbol strobe
//   i_is_data   - signed FIR output sample (sign bit is the decision)
//   i_ref_bit   - transmitted reference bit, used on strobes only
//   o_locked    - latency sweep finished
//   o_latency   - selected reference delay in symbols
//   o_bit_count - symbols compared while locked (saturating)
//   o_err_count - mismatches while locked (saturating)
// Build option: define BER_EARLY_LOCK_EN to lock at the end of the first
//               error-free window instead of sweeping all candidates.
// Revision    : 1.0 - initial release
// ============================================================================
module downsampler_ber
  import ber_pkg::*;
#(
  parameter int NB_INPUT = 8,
  parameter int OS       = OS_DEFAULT,
  parameter int NB_LAT   = NB_LAT_DEFAULT,
  parameter int NB_CNT   = NB_CNT_DEFAULT
) (
  input  logic                       clk,
  input  logic                       i_rst,
  input  logic                       i_en,
  input  logic [$clog2(OS)-1:0]      i_phase,
  input  logic signed [NB_INPUT-1:0] i_is_data,
  input  logic                       i_ref_bit,
  output logic                       o_locked,
  output logic [NB_LAT-1:0]          o_latency,
  output logic [NB_CNT-1:0]          o_bit_count,
  output logic [NB_CNT-1:0]          o_err_count
);

  localparam int NB_PH = $clog2(OS);
  localparam int W     = (2 ** NB_LAT) - 1;

`ifdef BER_EARLY_LOCK_EN
  localparam bit EARLY_LOCK = 1'b1;
`else
  localparam bit EARLY_LOCK = 1'b0;
`endif

  logic [NB_PH-1:0]  phase_q,   phase_d;
  logic [W-1:0]      ref_sr_q,  ref_sr_d;
  ber_state_e        state_q,   state_d;
  logic [NB_LAT-1:0] cand_q,    cand_d;
  logic [NB_LAT-1:0] best_q,    best_d;
  logic [NB_LAT-1:0] win_cnt_q, win_cnt_d;
  logic [NB_LAT-1:0] win_err_q, win_err_d;
  logic [NB_LAT-1:0] min_err_q, min_err_d;

  logic              strobe;
  logic              det_bit;
  logic [W:0]        ref_taps;
  logic [NB_LAT-1:0] tap_idx;
  logic              mismatch;
  logic [NB_LAT-1:0] err_now;
  logic              win_end;
  logic              bit_inc;
  logic              err_inc;
  logic              unused_data;

  // Only the sign of the sample forms the hard decision.
  assign det_bit     = i_is_data[NB_INPUT-1];
  assign unused_data = ^i_is_data[NB_INPUT-2:0];

  assign strobe = i_en && (phase_q == i_phase);

  // The live reference bit is tap 0, so W stored bits give the full
  // 2**NB_LAT taps: tap L is the bit that arrived L strobes earlier.
  assign ref_taps = {ref_sr_q, i_ref_bit};
  assign tap_idx  = (state_q == LOCKED) ? best_q : cand_q;
  assign mismatch = det_bit ^ ref_taps[tap_idx];

  // A window holds W strobes, so its error count never exceeds NB_LAT bits.
  assign err_now = win_err_q + NB_LAT'(mismatch);
  assign win_end = (win_cnt_q == NB_LAT'(W - 1));

  always_comb begin
    phase_d   = phase_q;
    ref_sr_d  = ref_sr_q;
    state_d   = state_q;
    cand_d    = cand_q;
    best_d    = best_q;
    win_cnt_d = win_cnt_q;
    win_err_d = win_err_q;
    min_err_d = min_err_q;

    // OS is a power of two, so natural wrap gives the modulo.
    if (i_en) begin
      phase_d = phase_q + NB_PH'(1);
    end

    if (strobe) begin
      ref_sr_d = ref_taps[W-1:0];
    end

    if (strobe && (state_q == SEARCH)) begin
      if (win_end) begin
        win_cnt_d = '0;
        win_err_d = '0;
        cand_d    = cand_q + NB_LAT'(1);
        // Strict less-than keeps the lower latency on ties.
        if (err_now < min_err_q) begin
          min_err_d = err_now;
          best_d    = cand_q;
        end
        if ((cand_q == {NB_LAT{1'b1}}) || (EARLY_LOCK && (err_now == '0))) begin
          state_d = LOCKED;
        end
      end else begin
        win_cnt_d = win_cnt_q + NB_LAT'(1);
        win_err_d = err_now;
      end
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      phase_q   <= '0;
      ref_sr_q  <= '0;
      state_q   <= SEARCH;
      cand_q    <= '0;
      best_q    <= '0;
      win_cnt_q <= '0;
      win_err_q <= '0;
      min_err_q <= '1;
    end else begin
      phase_q   <= phase_d;
      ref_sr_q  <= ref_sr_d;
      state_q   <= state_d;
      cand_q    <= cand_d;
      best_q    <= best_d;
      win_cnt_q <= win_cnt_d;
      win_err_q <= win_err_d;
      min_err_q <= min_err_d;
    end
  end

  assign bit_inc = strobe && (state_q == LOCKED);
  assign err_inc = bit_inc && mismatch;

  sat_counter #(
    .WIDTH (NB_CNT)
  ) u_bit_cnt (
    .clk     (clk),
    .i_rst   (i_rst),
    .i_inc   (bit_inc),
    .o_count (o_bit_count)
  );

  sat_counter #(
    .WIDTH (NB_CNT)
  ) u_err_cnt (
    .clk     (clk),
    .i_rst   (i_rst),
    .i_inc   (err_inc),
    .o_count (o_err_count)
  );

  assign o_locked  = (state_q == LOCKED);
  assign o_latency = best_q;

endmodule
`default_nettype wire

// File: tb/tb_downsampler_ber.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_downsampler_ber
// Description : Self-checking bench for downsampler_ber (OS=4, NB_LAT=4).
//               Instance A uses 16-bit counters, instance B 4-bit counters
//               so saturation is reachable. Honours BER_EARLY_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_downsampler_ber;

  localparam int NB_INPUT = 8;
  localparam int OS       = 4;
  localparam int NB_LAT   = 4;
  localparam int W        = 15;
  localparam int NB_CNT_A = 16;
  localparam int NB_CNT_B = 4;
  localparam int MAX_A    = 65535;
  localparam int MAX_B    = 15;
  localparam int EXP_LAT  = 5;
`ifdef BER_EARLY_LOCK_EN
  localparam int LOCK_STROBES = (EXP_LAT + 1) * W;
`else
  localparam int LOCK_STROBES = 16 * W;
`endif

  logic                       clk = 1'b0;
  logic                       i_rst;
  logic                       i_en;
  logic [1:0]                 i_phase;
  logic signed [NB_INPUT-1:0] i_is_data;
  logic                       i_ref_bit;
  logic                       locked_a, locked_b;
  logic [NB_LAT-1:0]          lat_a, lat_b;
  logic [NB_CNT_A-1:0]        bits_a, errs_a;
  logic [NB_CNT_B-1:0]        bits_b, errs_b;

  always #5 clk = ~clk;

  downsampler_ber #(.NB_INPUT(NB_INPUT), .OS(OS), .NB_LAT(NB_LAT), .NB_CNT(NB_CNT_A)) dut_a (
    .clk(clk), .i_rst(i_rst), .i_en(i_en), .i_phase(i_phase), .i_is_data(i_is_data),
    .i_ref_bit(i_ref_bit), .o_locked(locked_a), .o_latency(lat_a),
    .o_bit_count(bits_a), .o_err_count(errs_a));

  downsampler_ber #(.NB_INPUT(NB_INPUT), .OS(OS), .NB_LAT(NB_LAT), .NB_CNT(NB_CNT_B)) dut_b (
    .clk(clk), .i_rst(i_rst), .i_en(i_en), .i_phase(i_phase), .i_is_data(i_is_data),
    .i_ref_bit(i_ref_bit), .o_locked(locked_b), .o_latency(lat_b),
    .o_bit_count(bits_b), .o_err_count(errs_b));

  int total = 0;
  int bad   = 0;

  // Stimulus / reference model state
  logic [8:0] lfsr;
  bit         ref_hist[$];
  int         strobe_n;
  int         ph;
  int         exp_ba, exp_ea, exp_bb, exp_eb;

  typedef struct {int ba; int ea; int bb; int eb;} sb_t;
  sb_t sb_q[$];

  typedef struct {int phase; bit toggle; int n_locked; int period; int exp_bits; int exp_errs;} vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit prbs_next();
    bit nb;
    nb   = lfsr[8] ^ lfsr[4];
    lfsr = {lfsr[7:0], nb};
    return nb;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Pulse reset between clock edges; outputs must clear before any edge.
  task automatic async_reset();
    i_en = 1'b0;
    #2 i_rst = 1'b1;
    #1;
    check("rst locked_a", 64'(locked_a), 0);
    check("rst latency_a", 64'(lat_a), 0);
    check("rst bits_a", 64'(bits_a), 0);
    check("rst errs_a", 64'(errs_a), 0);
    check("rst bits_b", 64'(bits_b), 0);
    check("rst locked_b", 64'(locked_b), 0);
    @(negedge clk);
    #2 i_rst = 1'b0;
    @(negedge clk);
    ph       = 0;
    strobe_n = 0;
    lfsr     = 9'h1ff;
    ref_hist.delete();
    sb_q.delete();
    exp_ba = 0; exp_ea = 0; exp_bb = 0; exp_eb = 0;
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input bit en, input int period);
    bit   is_strobe, rb, db, flip, counted;
    int   k;
    sb_t  e;
    is_strobe = en && (ph == int'(i_phase));
    counted   = is_strobe && (strobe_n >= LOCK_STROBES);
    i_en      = en;
    if (is_strobe) begin
      k    = strobe_n - LOCK_STROBES;
      flip = counted && (period > 0) && ((k % period) == (period - 1));
      rb   = prbs_next();
      ref_hist.push_back(rb);
      db   = ((strobe_n >= EXP_LAT) ? ref_hist[strobe_n - EXP_LAT] : 1'b0) ^ flip;
      i_ref_bit = rb;
      i_is_data = db ? -8'sd64 : 8'sd64;
      if (counted) begin
        exp_ba = sat(exp_ba + 1, MAX_A);
        exp_ea = sat(exp_ea + int'(flip), MAX_A);
        exp_bb = sat(exp_bb + 1, MAX_B);
        exp_eb = sat(exp_eb + int'(flip), MAX_B);
        sb_q.push_back('{exp_ba, exp_ea, exp_bb, exp_eb});
      end
    end else begin
      i_ref_bit = 1'($urandom_range(0, 1));
      i_is_data = NB_INPUT'($urandom);
    end
    @(posedge clk);
    #1;
    if (en) ph = (ph + 1) % OS;
    if (is_strobe) begin
      if (strobe_n == LOCK_STROBES - 2) begin
        check("locked early", 64'(locked_a), 0);
      end
      if (strobe_n == LOCK_STROBES - 1) begin
        check("lock rise a", 64'(locked_a), 1);
        check("lock rise b", 64'(locked_b), 1);
        check("latency a", 64'(lat_a), EXP_LAT);
        check("latency b", 64'(lat_b), EXP_LAT);
        check("search errs a", 64'(errs_a), 0);
        check("search bits a", 64'(bits_a), 0);
      end
      if (counted) begin
        if (sb_q.size() == 0) begin
          check("scoreboard empty", 0, 1);
        end else begin
          e = sb_q.pop_front();
          check("sb bits_a", 64'(bits_a), 64'(e.ba));
          check("sb errs_a", 64'(errs_a), 64'(e.ea));
          check("sb bits_b", 64'(bits_b), 64'(e.bb));
          check("sb errs_b", 64'(errs_b), 64'(e.eb));
        end
      end
      strobe_n++;
    end
    @(negedge clk);
  endtask

  task automatic run_to(input int target, input bit toggle, input int period);
    int cyc;
    cyc = 0;
    while ((strobe_n < target) && (cyc < 20000)) begin
      step(toggle ? bit'(cyc % 2) : 1'b1, period);
      cyc++;
    end
    if (strobe_n < target) check("strobe budget", 64'(strobe_n), 64'(target));
  endtask

  initial begin
    i_rst = 1'b0; i_en = 1'b0; i_phase = 2'd0; i_is_data = '0; i_ref_bit = 1'b0;
    lfsr = 9'h1ff; strobe_n = 0; ph = 0;
    exp_ba = 0; exp_ea = 0; exp_bb = 0; exp_eb = 0;

    //           phase toggle locked_syms flip_period exp_bits exp_errs
    vecs[0] = '{0, 1'b0, 1000, 100, 1000, 10};
    vecs[1] = '{2, 1'b0,   50,   0,   50,  0};
    vecs[2] = '{0, 1'b1, 1000, 100, 1000, 10};
    vecs[3] = '{3, 1'b1,   30,   3,   30, 10};
    vecs[4] = '{1, 1'b0,   20,   1,   20, 20};

    @(negedge clk);
    async_reset();

    for (int v = 0; v < 5; v++) begin
      async_reset();
      i_phase = 2'(vecs[v].phase);
      run_to(LOCK_STROBES, vecs[v].toggle, vecs[v].period);
      run_to(LOCK_STROBES + vecs[v].n_locked, vecs[v].toggle, vecs[v].period);
      check("final latency", 64'(lat_a), EXP_LAT);
      check("final bits_a", 64'(bits_a), 64'(vecs[v].exp_bits));
      check("final errs_a", 64'(errs_a), 64'(vecs[v].exp_errs));
      check("final bits_b", 64'(bits_b), 64'(sat(vecs[v].exp_bits, MAX_B)));
      check("final errs_b", 64'(errs_b), 64'(sat(vecs[v].exp_errs, MAX_B)));
    end

    // Reset in the middle of the sweep, then a full relock.
    async_reset();
    i_phase = 2'd1;
    run_to(100, 1'b0, 0);
    async_reset();
    run_to(LOCK_STROBES, 1'b0, 0);
    check("relock latency", 64'(lat_a), EXP_LAT);

    // Phase change while locked only moves the strobes.
    run_to(LOCK_STROBES + 20, 1'b0, 0);
    i_phase = 2'd3;
    run_to(LOCK_STROBES + 40, 1'b0, 0);
    check("phase move locked", 64'(locked_a), 1);
    check("phase move bits", 64'(bits_a), 40);

    // Enable low freezes everything.
    for (int i = 0; i < 10; i++) step(1'b0, 0);
    check("freeze bits", 64'(bits_a), 64'(exp_ba));
    check("freeze errs", 64'(errs_a), 64'(exp_ea));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
